// File: rtl/game_pkg.sv
// Shared game-control constants and the target hit-state encoding.
package game_pkg;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;

  typedef enum logic [1:0] {
    HS_ALIVE,
    HS_INVULN,
    HS_DEAD
  } hit_state_e;
endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test between box A and box B.
module aabb_overlap
  import game_pkg::*;
#(
  parameter int A_W = 64,
  parameter int A_H = 64,
  parameter int B_W = 16,
  parameter int B_H = 8
) (
  input  logic [X_W-1:0] a_x,
  input  logic [Y_W-1:0] a_y,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  output logic           hit
);
  // One extra bit so right/bottom edges never wrap past the screen limit.
  logic [X_W:0] ax_e, bx_e;
  logic [Y_W:0] ay_e, by_e;

  assign ax_e = {1'b0, a_x};
  assign bx_e = {1'b0, b_x};
  assign ay_e = {1'b0, a_y};
  assign by_e = {1'b0, b_y};

  assign hit = (bx_e < ax_e + (X_W+1)'(A_W)) &&
               (bx_e + (X_W+1)'(B_W) > ax_e) &&
               (by_e < ay_e + (Y_W+1)'(A_H)) &&
               (by_e + (Y_W+1)'(B_H) > ay_e);
endmodule

// File: rtl/enemy_hit_receiver.sv
// Target-side bullet collision, consume strobe, hit points and invulnerability FSM.
module enemy_hit_receiver
  import game_pkg::*;
#(
  parameter int HP_INIT       = 10,
  parameter int DAMAGE        = 1,
  parameter int BOX_W         = 64,
  parameter int BOX_H         = 64,
  parameter int BUL_W         = 16,
  parameter int BUL_H         = 8,
  parameter int INVULN_FRAMES = 30
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           restart,
  input  logic [X_W-1:0] bul_x,
  input  logic [Y_W-1:0] bul_y,
  input  logic           bul_isE,
  input  logic [X_W-1:0] tgt_x,
  input  logic [Y_W-1:0] tgt_y,
  input  logic           tgt_defend,
  output logic           bul_kill,
  output logic           hit_pulse,
  output logic [7:0]     hp,
  output logic           invuln,
  output logic           flash,
  output logic           dead
);
  hit_state_e state_reg, state_next;
  logic [7:0] hp_reg, hp_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       kill_reg, kill_next;
  logic       hit_reg, hit_next;
  logic       invuln_reg, invuln_next;
  logic       flash_reg, flash_next;
  logic       dead_reg, dead_next;
  logic       overlap;
  logic       candidate;

  aabb_overlap #(
    .A_W(BOX_W),
    .A_H(BOX_H),
    .B_W(BUL_W),
    .B_H(BUL_H)
  ) u_overlap (
    .a_x(tgt_x),
    .a_y(tgt_y),
    .b_x(bul_x),
    .b_y(bul_y),
    .hit(overlap)
  );

  // Skipping the cycle right after a kill lets the source drop bul_isE first.
  assign candidate = bul_isE && overlap && !kill_reg;

  always_comb begin
    state_next = state_reg;
    hp_next    = hp_reg;
    cnt_next   = cnt_reg;
    kill_next  = 1'b0;
    hit_next   = 1'b0;
    if (restart) begin
      state_next = HS_ALIVE;
      hp_next    = 8'(HP_INIT);
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        HS_ALIVE: begin
          if (candidate) begin
            kill_next = 1'b1;
            if (!tgt_defend) begin
              hit_next = 1'b1;
              if (hp_reg > 8'(DAMAGE)) begin
                hp_next    = hp_reg - 8'(DAMAGE);
                state_next = HS_INVULN;
                cnt_next   = 8'(INVULN_FRAMES);
              end else begin
                hp_next    = 8'd0;
                state_next = HS_DEAD;
              end
            end
          end
        end
        HS_INVULN: begin
          kill_next = candidate;
          if (tick) begin
            if (cnt_reg <= 8'd1) begin
              cnt_next   = 8'd0;
              state_next = HS_ALIVE;
            end else begin
              cnt_next = cnt_reg - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
    invuln_next = (state_next == HS_INVULN);
    flash_next  = (state_next == HS_INVULN) && cnt_next[2];
    dead_next   = (state_next == HS_DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= HS_ALIVE;
      hp_reg     <= 8'(HP_INIT);
      cnt_reg    <= 8'd0;
      kill_reg   <= 1'b0;
      hit_reg    <= 1'b0;
      invuln_reg <= 1'b0;
      flash_reg  <= 1'b0;
      dead_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hp_reg     <= hp_next;
      cnt_reg    <= cnt_next;
      kill_reg   <= kill_next;
      hit_reg    <= hit_next;
      invuln_reg <= invuln_next;
      flash_reg  <= flash_next;
      dead_reg   <= dead_next;
    end
  end

  assign bul_kill  = kill_reg;
  assign hit_pulse = hit_reg;
  assign hp        = hp_reg;
  assign invuln    = invuln_reg;
  assign flash     = flash_reg;
  assign dead      = dead_reg;
endmodule

// File: tb/tb_enemy_hit_receiver.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor checks them.
module tb_enemy_hit_receiver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        restart = 1'b0;
  logic [10:0] bul_x = '0;
  logic [9:0]  bul_y = '0;
  logic        bul_isE = 1'b0;
  logic [10:0] tgt_x = '0;
  logic [9:0]  tgt_y = '0;
  logic        tgt_defend = 1'b0;
  logic        bul_kill, hit_pulse, invuln, flash, dead;
  logic [7:0]  hp;

  enemy_hit_receiver dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .restart(restart),
    .bul_x(bul_x), .bul_y(bul_y), .bul_isE(bul_isE),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_defend(tgt_defend),
    .bul_kill(bul_kill), .hit_pulse(hit_pulse), .hp(hp),
    .invuln(invuln), .flash(flash), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       kill;
    logic       hit;
    logic [7:0] hp;
    logic       inv;
    logic       dead;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor: every cycle with a strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (bul_kill || hit_pulse)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe t=%0t: kill=%0b hit=%0b hp=%0d, required no strobe",
                 $time, bul_kill, hit_pulse, hp);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bul_kill !== e.kill || hit_pulse !== e.hit || hp !== e.hp ||
            invuln !== e.inv || dead !== e.dead) begin
          n_err++;
          $display("FAIL strobe t=%0t: got kill=%0b hit=%0b hp=%0d inv=%0b dead=%0b, required kill=%0b hit=%0b hp=%0d inv=%0b dead=%0b",
                   $time, bul_kill, hit_pulse, hp, invuln, dead,
                   e.kill, e.hit, e.hp, e.inv, e.dead);
        end else begin
          $display("strobe t=%0t kill=%0b hit=%0b hp=%0d inv=%0b dead=%0b ok",
                   $time, bul_kill, hit_pulse, hp, invuln, dead);
        end
      end
    end
  end

  task automatic push(input logic k, input logic h, input logic [7:0] p,
                      input logic i, input logic d);
    exp_t e;
    e.kill = k; e.hit = h; e.hp = p; e.inv = i; e.dead = d;
    exp_q.push_back(e);
  endtask

  task automatic check_state(input string name, input logic [7:0] e_hp,
                             input logic e_inv, input logic e_dead, input logic e_flash);
    n_vec++;
    if (hp !== e_hp || invuln !== e_inv || dead !== e_dead || flash !== e_flash) begin
      n_err++;
      $display("FAIL %s: got hp=%0d inv=%0b dead=%0b flash=%0b, required hp=%0d inv=%0b dead=%0b flash=%0b",
               name, hp, invuln, dead, flash, e_hp, e_inv, e_dead, e_flash);
    end else begin
      $display("state %s hp=%0d inv=%0b dead=%0b flash=%0b ok", name, hp, invuln, dead, flash);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic e);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %0b, required %0b", name, act, e);
    end else begin
      $display("bit %s=%0b ok", name, act);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  // Overlap-edge vectors that must not kill: {bul_x, bul_y, tgt_x, tgt_y}
  logic [10:0] nk_bx [4] = '{11'd154, 11'd10,  11'd100, 11'd100};
  logic [9:0]  nk_by [4] = '{10'd100, 10'd100, 10'd144, 10'd72};
  logic [10:0] nk_tx [4] = '{11'd90,  11'd2000, 11'd90, 11'd90};
  logic [9:0]  nk_ty [4] = '{10'd80,  10'd80,  10'd80,  10'd80};

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("reset", 8'd10, 1'b0, 1'b0, 1'b0);
    check_bit("reset_kill", bul_kill, 1'b0);
    check_bit("reset_hit", hit_pulse, 1'b0);

    // First damaging hit
    tgt_x = 11'd90; tgt_y = 10'd80; bul_x = 11'd100; bul_y = 10'd100;
    bul_isE = 1'b1;
    push(1'b1, 1'b1, 8'd9, 1'b1, 1'b0);
    @(negedge clk);
    bul_isE = 1'b0;
    @(negedge clk);
    check_bit("first_kill_one_cycle", bul_kill, 1'b0);
    check_state("first_hit", 8'd9, 1'b1, 1'b0, 1'b1);

    // Held bullet during invulnerability: kill, guard, kill; no damage
    bul_isE = 1'b1;
    push(1'b1, 1'b0, 8'd9, 1'b1, 1'b0);
    push(1'b1, 1'b0, 8'd9, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    bul_isE = 1'b0;
    @(negedge clk);
    check_state("invuln_hold", 8'd9, 1'b1, 1'b0, 1'b1);

    tick_n(4);
    check_state("flash_off_cnt26", 8'd9, 1'b1, 1'b0, 1'b0);
    tick_n(25);
    check_state("invuln_cnt1", 8'd9, 1'b1, 1'b0, 1'b0);
    tick_n(1);
    check_state("invuln_end", 8'd9, 1'b0, 1'b0, 1'b0);

    // Blocking target: kill only
    tgt_defend = 1'b1; bul_isE = 1'b1;
    push(1'b1, 1'b0, 8'd9, 1'b0, 1'b0);
    @(negedge clk);
    bul_isE = 1'b0;
    @(negedge clk);
    check_state("defend", 8'd9, 1'b0, 1'b0, 1'b0);

    // Right-edge overlap that only holds without wraparound
    tgt_x = 11'd2000; bul_x = 11'd2040; bul_isE = 1'b1;
    push(1'b1, 1'b0, 8'd9, 1'b0, 1'b0);
    @(negedge clk);
    bul_isE = 1'b0;
    @(negedge clk);
    tgt_defend = 1'b0;

    for (int v = 0; v < 4; v++) begin
      bul_x = nk_bx[v]; bul_y = nk_by[v]; tgt_x = nk_tx[v]; tgt_y = nk_ty[v];
      bul_isE = 1'b1;
      repeat (3) @(negedge clk);
      bul_isE = 1'b0;
      @(negedge clk);
    end
    check_state("no_kill_edges", 8'd9, 1'b0, 1'b0, 1'b0);

    // Remaining nine hits down to death
    tgt_x = 11'd90; tgt_y = 10'd80; bul_x = 11'd100; bul_y = 10'd100;
    for (int h = 8; h >= 0; h--) begin
      bul_isE = 1'b1;
      push(1'b1, 1'b1, 8'(h), (h != 0), (h == 0));
      @(negedge clk);
      bul_isE = 1'b0;
      @(negedge clk);
      if (h != 0) begin
        tick = 1'b1;
        repeat (30) @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
      end
    end
    check_state("dead", 8'd0, 1'b0, 1'b1, 1'b0);
    bul_isE = 1'b1;
    repeat (3) @(negedge clk);
    bul_isE = 1'b0;
    @(negedge clk);
    check_state("dead_pass_through", 8'd0, 1'b0, 1'b1, 1'b0);

    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    check_state("restart", 8'd10, 1'b0, 1'b0, 1'b0);

    // Restart overrides a simultaneous candidate
    bul_isE = 1'b1; restart = 1'b1;
    @(negedge clk);
    bul_isE = 1'b0; restart = 1'b0;
    check_bit("restart_hit_kill", bul_kill, 1'b0);
    check_bit("restart_hit_pulse", hit_pulse, 1'b0);
    check_state("restart_hit", 8'd10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of invulnerability
    bul_isE = 1'b1;
    push(1'b1, 1'b1, 8'd9, 1'b1, 1'b0);
    @(negedge clk);
    bul_isE = 1'b0;
    tick_n(3);
    check_state("pre_async_rst", 8'd9, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 8'd10, 1'b0, 1'b0, 1'b0);
    check_bit("async_rst_kill", bul_kill, 1'b0);
    check_bit("async_rst_hit", hit_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("post_rst", 8'd10, 1'b0, 1'b0, 1'b0);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_strobes: %0d expected strobes never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
